// File: rtl/cwalk_pkg.sv
// ============================================================================
// Module   : cwalk_pkg
// Brief    : Shared state encoding, timer width and default phase durations.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cwalk_pkg;

  localparam int c_TMR_W = 4;

  localparam int c_GREEN_T_DEF  = 8;
  localparam int c_YELLOW_T_DEF = 3;
  localparam int c_WALK_T_DEF   = 5;
  localparam int c_FLASH_T_DEF  = 9;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_WALK   = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cwalk_timer.sv
// ============================================================================
// Module   : cwalk_timer
// Brief    : 4-bit load/decrement down-timer that saturates at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cwalk_timer
  import cwalk_pkg::*;
#(
  parameter logic [c_TMR_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               dec,
  input  logic [c_TMR_W-1:0] value,
  output logic               zero,
  output logic [c_TMR_W-1:0] count
);

  logic [c_TMR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero  = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cwalk_ctrl.sv
// ============================================================================
// Module   : cwalk_ctrl
// Brief    : Pedestrian-crossing controller: Moore FSM, lamp decode, countdown.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cwalk_ctrl
  import cwalk_pkg::*;
#(
  parameter int GREEN_T  = c_GREEN_T_DEF,
  parameter int YELLOW_T = c_YELLOW_T_DEF,
  parameter int WALK_T   = c_WALK_T_DEF,
  parameter int FLASH_T  = c_FLASH_T_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               btn,
  output logic               car_g,
  output logic               car_y,
  output logic               car_r,
  output logic               walk,
  output logic               dont_walk,
  output logic [c_TMR_W-1:0] cnt_d,
  output logic               cnt_en,
  output logic               req_pend
);

  localparam logic [c_TMR_W-1:0] c_GREEN_LD  = c_TMR_W'(GREEN_T - 1);
  localparam logic [c_TMR_W-1:0] c_YELLOW_LD = c_TMR_W'(YELLOW_T - 1);
  localparam logic [c_TMR_W-1:0] c_WALK_LD   = c_TMR_W'(WALK_T - 1);
  localparam logic [c_TMR_W-1:0] c_FLASH_LD  = c_TMR_W'(FLASH_T - 1);

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_load;
  logic               w_dec;
  logic [c_TMR_W-1:0] w_value;
  logic               w_zero;
  logic [c_TMR_W-1:0] w_count;
  logic               r_blink;
  logic               r_req_pend;
  logic               r_flash_upd;
  logic               r_blank_upd;
  logic [c_TMR_W-1:0] r_cnt_d;
  logic               r_cnt_en;

  cwalk_timer #(
    .RST_VAL (c_GREEN_LD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec),
    .value (w_value),
    .zero  (w_zero),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_GREEN;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_value    = c_GREEN_LD;
    if (tick) begin
      if (!w_zero) begin
        w_dec = 1'b1;
      end else begin
        unique case (r_state)
          ST_GREEN: begin
            // GREEN parks at zero until a request is pending or arriving now
            if (r_req_pend || btn) begin
              w_state_nx = ST_YELLOW;
              w_load     = 1'b1;
              w_value    = c_YELLOW_LD;
            end
          end
          ST_YELLOW: begin
            w_state_nx = ST_WALK;
            w_load     = 1'b1;
            w_value    = c_WALK_LD;
          end
          ST_WALK: begin
            w_state_nx = ST_FLASH;
            w_load     = 1'b1;
            w_value    = c_FLASH_LD;
          end
          ST_FLASH: begin
            w_state_nx = ST_GREEN;
            w_load     = 1'b1;
            w_value    = c_GREEN_LD;
          end
        endcase
      end
    end
  end

  always_comb begin
    car_g     = 1'b0;
    car_y     = 1'b0;
    car_r     = 1'b0;
    walk      = 1'b0;
    dont_walk = 1'b0;
    unique case (r_state)
      ST_GREEN:  begin car_g = 1'b1; dont_walk = 1'b1;    end
      ST_YELLOW: begin car_y = 1'b1; dont_walk = 1'b1;    end
      ST_WALK:   begin car_r = 1'b1; walk      = 1'b1;    end
      ST_FLASH:  begin car_r = 1'b1; dont_walk = r_blink; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_pend  <= 1'b0;
      r_blink     <= 1'b0;
      r_flash_upd <= 1'b0;
      r_blank_upd <= 1'b0;
      r_cnt_d     <= '0;
      r_cnt_en    <= 1'b0;
    end else begin
      // Clear on WALK entry takes priority over a coincident press
      if (w_load && (w_state_nx == ST_WALK))
        r_req_pend <= 1'b0;
      else if (btn && ((r_state == ST_GREEN) || (r_state == ST_YELLOW)))
        r_req_pend <= 1'b1;

      if (w_load && (w_state_nx == ST_FLASH))
        r_blink <= 1'b1;
      else if ((r_state == ST_FLASH) && tick)
        r_blink <= ~r_blink;

      // Display strobe trails the timer update by one edge so cnt_d sees the new count
      r_flash_upd <= (w_load && (w_state_nx == ST_FLASH)) || ((r_state == ST_FLASH) && w_dec);
      r_blank_upd <= (r_state == ST_FLASH) && (w_state_nx == ST_GREEN);
      r_cnt_en    <= r_flash_upd || r_blank_upd;
      if (r_flash_upd)
        r_cnt_d <= w_count + 1'b1;
      else if (r_blank_upd)
        r_cnt_d <= '0;
    end
  end

  assign cnt_d    = r_cnt_d;
  assign cnt_en   = r_cnt_en;
  assign req_pend = r_req_pend;

endmodule

`default_nettype wire

// File: tb/tb_cwalk_ctrl.sv
// Bench for cwalk_ctrl: directed scenarios plus random tick/btn traffic against
// a phase/remaining-ticks reference model.
`default_nettype none

module tb_cwalk_ctrl;

  localparam int GT = 8;
  localparam int YT = 3;
  localparam int WT = 5;
  localparam int FT = 9;
  localparam logic [10:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       car_g, car_y, car_r, walk, dont_walk, cnt_en, req_pend;
  logic [3:0] cnt_d;
  logic [10:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=GREEN 1=YELLOW 2=WALK 3=FLASH, ticks left in phase
  int m_st, m_tmr, m_d, m_pend;
  bit m_blink, m_req, m_en;

  cwalk_ctrl #(
    .GREEN_T  (GT),
    .YELLOW_T (YT),
    .WALK_T   (WT),
    .FLASH_T  (FT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn       (btn),
    .car_g     (car_g),
    .car_y     (car_y),
    .car_r     (car_r),
    .walk      (walk),
    .dont_walk (dont_walk),
    .cnt_d     (cnt_d),
    .cnt_en    (cnt_en),
    .req_pend  (req_pend)
  );

  assign dut_vec = {car_g, car_y, car_r, walk, dont_walk, cnt_en, cnt_d, req_pend};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_tmr = GT - 1; m_blink = 0; m_req = 0; m_en = 0; m_d = 0; m_pend = -1;
  endtask

  task automatic model_step(input bit t, input bit b);
    bit nreq;
    int npend;
    m_en = (m_pend >= 0);
    if (m_pend >= 0) m_d = m_pend;
    npend = -1;
    nreq  = m_req | (b && (m_st <= 1));
    if (t) begin
      if (m_tmr > 0) begin
        m_tmr = m_tmr - 1;
        if (m_st == 3) begin
          npend   = m_tmr + 1;
          m_blink = !m_blink;
        end
      end else begin
        case (m_st)
          0: if (m_req || b) begin m_st = 1; m_tmr = YT - 1; end
          1: begin m_st = 2; m_tmr = WT - 1; nreq = 0; end
          2: begin m_st = 3; m_tmr = FT - 1; m_blink = 1; npend = FT; end
          default: begin m_st = 0; m_tmr = GT - 1; npend = 0; end
        endcase
      end
    end
    m_req  = nreq;
    m_pend = npend;
  endtask

  function automatic logic [10:0] exp_vec();
    logic g, y, r, w, dw;
    g  = (m_st == 0);
    y  = (m_st == 1);
    r  = (m_st >= 2);
    w  = (m_st == 2);
    dw = (m_st <= 1) || ((m_st == 3) && m_blink);
    return {g, y, r, w, dw, m_en, 4'(m_d), m_req};
  endfunction

  task automatic cycle(input bit t, input bit b);
    tick = t;
    btn  = b;
    @(posedge clk);
    if (reset) model_step(t, b);
    #1;
    tick = 1'b0;
    btn  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    cycle(0, 0);
    cycle(0, 0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    model_reset();
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_initial got=%b exp=%b", dut_vec, RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1);
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++;
        $display("FAIL reset_held cyc=%0d got=%b exp=%b", i, dut_vec, RST_VEC);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_idle_green();
    apply_reset();
    for (int n = 1; n <= 20; n++) begin
      cycle(1, 0);
      checks++;
      if (dut_vec !== exp_vec() || car_g !== 1'b1 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_green tick=%0d got=%b exp=%b", n, dut_vec, exp_vec());
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        cycle(0, 0);
        checks++;
        if (car_g !== 1'b1 || cnt_en !== 1'b0) begin
          errors++;
          $display("FAIL idle_green_gap tick=%0d car_g=%b cnt_en=%b exp car_g=1 cnt_en=0", n, car_g, cnt_en);
        end
      end
    end
  endtask

  task automatic test_ped_cycle();
    int pulses[$];
    int exp_p;
    apply_reset();
    for (int n = 1; n <= 25; n++) begin
      cycle(1, 0);
      if (cnt_en) pulses.push_back(int'(cnt_d));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ped_vec tick=%0d got=%b exp=%b", n, dut_vec, exp_vec());
      end
      checks++;
      if ((n <= 7 && car_g !== 1'b1) || (n >= 8 && n <= 10 && car_y !== 1'b1) ||
          (n >= 11 && n <= 15 && (walk !== 1'b1 || req_pend !== 1'b0)) ||
          (n >= 16 && n <= 24 && (car_r !== 1'b1 || walk !== 1'b0 || dont_walk !== ((n - 16) % 2 == 0))) ||
          (n == 25 && car_g !== 1'b1)) begin
        errors++;
        $display("FAIL ped_phase tick=%0d g=%b y=%b r=%b w=%b dw=%b rp=%b", n, car_g, car_y, car_r, walk, dont_walk, req_pend);
      end
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        cycle(0, (n == 2 && k == 0));
        if (cnt_en) pulses.push_back(int'(cnt_d));
        if (n == 2 && k == 0) begin
          checks++;
          if (req_pend !== 1'b1) begin
            errors++;
            $display("FAIL ped_req_latch got=%b exp=1", req_pend);
          end
        end
      end
    end
    checks++;
    if (pulses.size() != FT + 1) begin
      errors++;
      $display("FAIL ped_pulse_count got=%0d exp=%0d", pulses.size(), FT + 1);
    end else begin
      for (int i = 0; i <= FT; i++) begin
        exp_p = (i == FT) ? 0 : FT - i;
        checks++;
        if (pulses[i] != exp_p) begin
          errors++;
          $display("FAIL ped_pulse idx=%0d got=%0d exp=%0d", i, pulses[i], exp_p);
        end
      end
    end
  endtask

  task automatic test_btn_at_walk_entry();
    apply_reset();
    cycle(1, 1);
    for (int n = 2; n <= 10; n++) cycle(1, 0);
    cycle(1, 1);
    checks++;
    if (walk !== 1'b1 || req_pend !== 1'b0) begin
      errors++;
      $display("FAIL walk_entry_clear walk=%b req_pend=%b exp walk=1 req_pend=0", walk, req_pend);
    end
    for (int n = 12; n <= 25; n++) begin
      cycle(0, 1);
      cycle(1, 1'($urandom_range(0, 1)));
      checks++;
      if (req_pend !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL walk_flash_btn tick=%0d got=%b exp=%b", n, dut_vec, exp_vec());
      end
    end
    cycle(0, 0);
    checks++;
    if (car_g !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL walk_flash_return got=%b exp=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_flash();
    apply_reset();
    cycle(1, 1);
    cycle(0, 0);
    for (int n = 2; n <= 21; n++) begin
      cycle(1, 0);
      cycle(0, 0);
    end
    checks++;
    if (cnt_en !== 1'b1 || cnt_d !== 4'd4 || car_r !== 1'b1) begin
      errors++;
      $display("FAIL flash_before_abort cnt_en=%b cnt_d=%0d car_r=%b exp 1/4/1", cnt_en, cnt_d, car_r);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++;
      $display("FAIL flash_abort_async got=%b exp=%b", dut_vec, RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0);
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++;
        $display("FAIL flash_abort_hold cyc=%0d got=%b exp=%b", i, dut_vec, RST_VEC);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_freeze();
    logic [10:0] snap;
    apply_reset();
    cycle(1, 1);
    for (int n = 2; n <= 9; n++) cycle(1, 0);
    snap = dut_vec;
    checks++;
    if (car_y !== 1'b1) begin
      errors++;
      $display("FAIL freeze_in_yellow car_y=%b exp=1", car_y);
    end
    for (int i = 0; i < 50; i++) begin
      cycle(0, (i == 25));
      checks++;
      if (dut_vec !== snap) begin
        errors++;
        $display("FAIL freeze_yellow cyc=%0d got=%b exp=%b", i, dut_vec, snap);
      end
    end
    cycle(1, 0);
    checks++;
    if (car_y !== 1'b1) begin
      errors++;
      $display("FAIL freeze_tick10 car_y=%b exp=1", car_y);
    end
    cycle(1, 0);
    checks++;
    if (walk !== 1'b1) begin
      errors++;
      $display("FAIL freeze_tick11 walk=%b exp=1", walk);
    end
    apply_reset();
    for (int i = 0; i < 50; i++) cycle(0, (i == 20));
    checks++;
    if (req_pend !== 1'b1 || car_g !== 1'b1) begin
      errors++;
      $display("FAIL freeze_green_btn req_pend=%b car_g=%b exp 1/1", req_pend, car_g);
    end
    for (int n = 1; n <= 7; n++) cycle(1, 0);
    checks++;
    if (car_g !== 1'b1) begin
      errors++;
      $display("FAIL freeze_green_tick7 car_g=%b exp=1", car_g);
    end
    cycle(1, 0);
    checks++;
    if (car_y !== 1'b1) begin
      errors++;
      $display("FAIL freeze_green_tick8 car_y=%b exp=1", car_y);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL rand_reset cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
        end
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset = 1'b1;
      end else begin
        cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_vec cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_green();
    test_ped_cycle();
    test_btn_at_walk_entry();
    test_reset_mid_flash();
    test_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cwalk_ctrl.md
CWALK_CTRL -- requirements
Module: cwalk_ctrl

Interface
REQ-001 SHALL have parameter GREEN_T, default 8, meaning minimum car-green ticks.
REQ-002 SHALL have parameter YELLOW_T, default 3, meaning car-yellow ticks.
REQ-003 SHALL have parameter WALK_T, default 5, meaning steady-walk ticks.
REQ-004 SHALL have parameter FLASH_T, default 9, meaning flashing don't-walk ticks (max 15).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset (0 = reset).
REQ-007 SHALL have port tick, input, 1 bit, meaning one-cycle timebase enable pulse (nominally 1 Hz).
REQ-008 SHALL have port btn, input, 1 bit, meaning synchronous pedestrian request, sampled every clk.
REQ-009 SHALL have ports car_g, car_y, car_r, input/output as outputs, 1 bit each, meaning car lamps.
REQ-010 SHALL have ports walk, dont_walk, output, 1 bit each, meaning pedestrian lamps.
REQ-011 SHALL have port cnt_d, output, 4 bits, meaning countdown value for the downstream 4-bit enabled display register.
REQ-012 SHALL have port cnt_en, output, 1 bit, meaning load strobe for that register.
REQ-013 SHALL have port req_pend, output, 1 bit, meaning latched pedestrian request.

Function
REQ-014 SHALL implement a Moore FSM with states GREEN, YELLOW, WALK, FLASH and a 4-bit down-timer.
REQ-015 Timer SHALL change only on cycles with tick=1: if timer!=0, decrement by 1; if timer==0, evaluate transition.
REQ-016 On a transition, the timer SHALL load the new state's duration minus 1, in the same edge.
REQ-017 GREEN at timer 0 with tick: go to YELLOW if req_pend=1 or btn=1; otherwise stay GREEN with timer held at 0.
REQ-018 YELLOW -> WALK, WALK -> FLASH, and FLASH -> GREEN SHALL occur at timer 0 with tick, unconditionally.
REQ-019 Lamp decode: GREEN gives car_g=1, dont_walk=1; YELLOW gives car_y=1, dont_walk=1; WALK gives car_r=1, walk=1; FLASH gives car_r=1, with dont_walk=blink. All other lamps SHALL be 0.
REQ-020 Blink SHALL be set to 1 on FLASH entry and toggle on every tick while in FLASH.
REQ-021 req_pend SHALL set on btn=1 in GREEN or YELLOW, and SHALL clear on the edge entering WALK; btn in WALK or FLASH SHALL be ignored.
REQ-022 If btn=1 coincides with WALK entry, clear SHALL win and req_pend SHALL be 0 afterwards.
REQ-023 tick=0 SHALL freeze the timer, state and blink; btn latching SHALL still operate.
REQ-024 cnt_d and cnt_en SHALL be registered; cnt_en SHALL be a one-cycle pulse on the edge after any FLASH-state timer load or decrement, with cnt_d = new timer value + 1 (FLASH_T down to 1).
REQ-025 On FLASH -> GREEN, the next edge SHALL give cnt_en=1 and cnt_d=0 (blank); cnt_en SHALL be 0 at all other times.
REQ-026 Timer arithmetic SHALL be 4-bit unsigned and SHALL never wrap below 0.

Reset
REQ-027 While reset=0, outputs SHALL be forced asynchronously to: state GREEN, timer GREEN_T-1, blink 0, req_pend 0, cnt_d 0, cnt_en 0, car_g 1, dont_walk 1, all other lamps 0.
REQ-028 Reset asserted mid-FLASH or mid-WALK SHALL abort immediately to the REQ-027 state, with no cnt_en pulse.
REQ-029 The first evaluation after reset release SHALL use the first tick.

Structure
REQ-030 State encoding (2-bit) and default durations SHALL reside in shared package cwalk_pkg.
REQ-031 The 4-bit load/decrement timer SHALL be a sub-module cwalk_timer (inputs load, dec, value; output zero flag, count).

Verification
REQ-032 Reset release, 20 ticks, btn=0 -> stays GREEN, car_g=1, cnt_en never pulses.
REQ-033 btn pulse at tick 2 -> req_pend=1; YELLOW after tick 8, WALK after tick 11 with req_pend=0, FLASH after tick 16.
REQ-034 In FLASH -> cnt_en pulses 9 times with cnt_d 9,8,...,1, dont_walk toggles 1,0,1,...; then GREEN with cnt_d=0 strobed.
REQ-035 btn held at the same edge as WALK entry -> req_pend=0 afterwards; btn during WALK/FLASH -> req_pend stays 0.
REQ-036 reset=0 asserted between ticks in FLASH with cnt_d=4 -> lamps and outputs immediately match REQ-027, cnt_d=0.
REQ-037 tick held 0 for 50 cycles mid-YELLOW -> state and timer unchanged; btn still sets req_pend.
